icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache between the core's instruction bus (ibus request/response) and the cache bus (CBus) toward the memory arbiter. It serves fetches that hit in one cycle and refills a full line with one burst on a miss. It is the block directly downstream of the core's fetch port.

---
 rtl/icache_direct_pkg.sv | 50 +++++
 rtl/icache_line_ram.sv | 29 ++
 rtl/icache_direct.sv | 171 +++++++++++++++++
 tb/tb_icache_direct.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared bus types and cache-local constants for the direct-mapped instruction cache.
// Optional build macro: ICACHE_UNCACHED_EN (uncached path for addr[31]=0).
package icache_direct_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef logic [1:0] icache_state_t;
  localparam icache_state_t S_IDLE     = 2'd0;
  localparam icache_state_t S_REFILL   = 2'd1;
  localparam icache_state_t S_UNCACHED = 2'd2;
  localparam icache_state_t S_RESP     = 2'd3;

  // AXI burst length field holds the number of beats minus one.
  function automatic logic [7:0] axi_len(input int unsigned beats);
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Line data array: one write port and a combinational read port, both addressed by (index, word).
module icache_line_ram
  import icache_direct_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(NUM_LINES)-1:0]  widx,
  input  logic [$clog2(LINE_WORDS)-1:0] wword,
  input  logic [63:0]                   wdata,
  input  logic [$clog2(NUM_LINES)-1:0]  ridx,
  input  logic [$clog2(LINE_WORDS)-1:0] rword,
  output logic [63:0]                   rdata
);

  localparam int IB = $clog2(NUM_LINES);
  localparam int WB = $clog2(LINE_WORDS);

  logic [63:0] mem [NUM_LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[{widx, wword}] <= wdata;
  end

  assign rdata = mem[{ridx, rword}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: single-cycle hits, one-burst line refill on miss.
// Optional build macro: ICACHE_UNCACHED_EN enables the UNCACHED/RESP path for addr[31]=0.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       flush
);

  localparam int OB = $clog2(LINE_WORDS * 8);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = 64 - OB - IB;
  localparam int WB = $clog2(LINE_WORDS);

  icache_state_t        state;
  logic [NUM_LINES-1:0] valid_q;
  logic [TB-1:0]        tag_arr [NUM_LINES];
  logic [WB-1:0]        cnt_q;
  logic                 flush_pend_q;
  logic [63:0]          base_q;
  logic [IB-1:0]        idx_q;
  logic [TB-1:0]        tag_q;

  logic [IB-1:0] req_idx;
  logic [TB-1:0] req_tag;
  logic [WB-1:0] req_word;
  logic [63:0]   rd_word;
  logic          cacheable;
  logic          hit;
  logic          fill_we;
  logic          fill_done;

  assign req_idx  = ireq.addr[OB+IB-1:OB];
  assign req_tag  = ireq.addr[63:OB+IB];
  assign req_word = ireq.addr[OB-1:3];

`ifdef ICACHE_UNCACHED_EN
  logic [63:0] unc_addr_q;
  logic [31:0] unc_data_q;
  assign cacheable = ireq.addr[31];
`else
  assign cacheable = 1'b1;
`endif

  assign hit       = (state == S_IDLE) && ireq.valid && cacheable &&
                     valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign fill_we   = (state == S_REFILL) && cresp.ready;
  assign fill_done = fill_we && cresp.last;

  icache_line_ram #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_ram (
    .clk   (clk),
    .we    (fill_we),
    .widx  (idx_q),
    .wword (cnt_q),
    .wdata (cresp.data),
    .ridx  (req_idx),
    .rword (req_word),
    .rdata (rd_word)
  );

  // Control state: FSM, valid bits, beat counter, flush seen during a refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      valid_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ireq.valid && !hit) begin
            cnt_q <= '0;
`ifdef ICACHE_UNCACHED_EN
            state <= cacheable ? S_REFILL : S_UNCACHED;
`else
            state <= S_REFILL;
`endif
          end
        end
        S_REFILL: begin
          if (fill_we) cnt_q <= cnt_q + 1'b1;
          if (fill_done) begin
            cnt_q        <= '0;
            state        <= S_IDLE;
            flush_pend_q <= 1'b0;
            if (!flush_pend_q && !flush) valid_q[idx_q] <= 1'b1;
          end else if (flush) begin
            flush_pend_q <= 1'b1;
          end
        end
`ifdef ICACHE_UNCACHED_EN
        S_UNCACHED: if (cresp.ready) state <= S_RESP;
        S_RESP:     state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
      // A flush wipes every line, including one whose install was just suppressed above.
      if (flush) valid_q <= '0;
    end
  end

  // Miss context and tag array: data only, never reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && ireq.valid && !hit) begin
      base_q <= {ireq.addr[63:OB], {OB{1'b0}}};
      idx_q  <= req_idx;
      tag_q  <= req_tag;
`ifdef ICACHE_UNCACHED_EN
      unc_addr_q <= ireq.addr;
`endif
    end
    if (fill_done) tag_arr[idx_q] <= tag_q;
`ifdef ICACHE_UNCACHED_EN
    if (state == S_UNCACHED && cresp.ready)
      unc_data_q <= cresp.data[unc_addr_q[2]*32 +: 32];
`endif
  end

  always_comb begin
    iresp = '0;
    if (!reset) begin
      if (hit) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = ireq.addr[2] ? rd_word[63:32] : rd_word[31:0];
      end
`ifdef ICACHE_UNCACHED_EN
      if (state == S_RESP) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = unc_data_q;
      end
`endif
    end
  end

  always_comb begin
    creq = '0;
    if (!reset) begin
      if (state == S_REFILL) begin
        creq.valid = 1'b1;
        creq.size  = MSIZE8;
        creq.addr  = base_q;
        creq.len   = axi_len(LINE_WORDS);
      end
`ifdef ICACHE_UNCACHED_EN
      if (state == S_UNCACHED) begin
        creq.valid = 1'b1;
        creq.size  = MSIZE4;
        creq.addr  = unc_addr_q;
        creq.len   = axi_len(1);
      end
`endif
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^ireq.addr[1:0];

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: table of fetch vectors plus hand-written flush/reset/uncached sequences.
module tb_icache_direct;
  import icache_direct_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       flush;

  int checks = 0;
  int failures = 0;

  icache_direct #(.NUM_LINES(16), .LINE_WORDS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .creq  (creq),
    .cresp (cresp),
    .flush (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        miss;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge on which the cache moved into REFILL.
  task automatic serve_burst(input logic [63:0] base, input int flush_beat);
    for (int k = 0; k < 8; k++) begin
      cresp.ready = 1'b1;
      cresp.last  = (k == 7);
      cresp.data  = mem_word(base + 64'(8 * k));
      flush       = (k == flush_beat);
      #1;
      chk("burst_valid", 64'(creq.valid), 64'd1);
      chk("burst_addr", creq.addr, base);
      if (k == 0) begin
        chk("burst_len", 64'(creq.len), 64'd7);
        chk("burst_size", 64'(creq.size), 64'(MSIZE8));
        chk("burst_write", {creq.is_write, creq.strobe, creq.data[54:0]}, 64'd0);
      end
      chk("no_resp_in_refill", 64'(iresp.data_ok), 64'd0);
      tick();
      flush = 1'b0;
    end
    cresp = '0;
  endtask

  task automatic fetch(input logic [63:0] addr, input logic miss, input logic [31:0] data);
    logic [63:0] base;
    base = {addr[63:6], 6'd0};
    ireq.valid = 1'b1;
    ireq.addr  = addr;
    #1;
    chk("first_cycle_data_ok", 64'(iresp.data_ok), 64'(!miss));
    if (miss) begin
      tick();
      serve_burst(base, -1);
      #1;
      chk("after_fill_data_ok", 64'(iresp.data_ok), 64'd1);
    end else begin
      chk("hit_no_creq", 64'(creq.valid), 64'd0);
    end
    chk("fetch_data", 64'(iresp.data), 64'(data));
    chk("fetch_addr_ok", 64'(iresp.addr_ok), 64'd1);
    tick();
    ireq.valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    ireq  = '0;
    cresp = '0;

    vecs[0] = '{64'h8000_0000, 1'b1, 32'h8000_0000};
    vecs[1] = '{64'h8000_0004, 1'b0, 32'h7FFF_FFFF};
    vecs[2] = '{64'h8000_0038, 1'b0, 32'h8000_0038};
    vecs[3] = '{64'h8000_003C, 1'b0, 32'h7FFF_FFC7};
    vecs[4] = '{64'h8000_0400, 1'b1, 32'h8000_0400};
    vecs[5] = '{64'h8000_0000, 1'b1, 32'h8000_0000};
    vecs[6] = '{64'h8000_0044, 1'b1, 32'h7FFF_FFBF};
    vecs[7] = '{64'h8000_0040, 1'b0, 32'h8000_0040};

    tick();
    tick();
    chk("reset_iresp", 64'(iresp), 64'd0);
    chk("reset_creq_valid", 64'(creq.valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_creq", 64'(creq.valid), 64'd0);
    tick();

    for (int i = 0; i < 8; i++) fetch(vecs[i].addr, vecs[i].miss, vecs[i].data);

    // Flush in IDLE together with a hit: hit still served, then everything misses.
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0040;
    flush      = 1'b1;
    #1;
    chk("flush_hit_data_ok", 64'(iresp.data_ok), 64'd1);
    chk("flush_hit_data", 64'(iresp.data), 64'h8000_0040);
    tick();
    flush      = 1'b0;
    ireq.valid = 1'b0;
    fetch(64'h8000_0000, 1'b1, 32'h8000_0000);

    // Flush during the refill of 0x8000_0040: no install, the request refills again.
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0040;
    tick();
    serve_burst(64'h8000_0040, 3);
    #1;
    chk("flushed_fill_no_hit", 64'(iresp.data_ok), 64'd0);
    tick();
    chk("refetch_creq_valid", 64'(creq.valid), 64'd1);
    chk("refetch_creq_addr", creq.addr, 64'h8000_0040);
    serve_burst(64'h8000_0040, -1);
    #1;
    chk("refetch_data_ok", 64'(iresp.data_ok), 64'd1);
    chk("refetch_data", 64'(iresp.data), 64'h8000_0040);
    tick();
    ireq.valid = 1'b0;

    // Reset on the 3rd beat of a refill of 0x8000_0080.
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0080;
    tick();
    for (int k = 0; k < 3; k++) begin
      cresp.ready = 1'b1;
      cresp.last  = 1'b0;
      cresp.data  = mem_word(64'h8000_0080 + 64'(8 * k));
      reset       = (k == 2);
      #1;
      if (k == 2) chk("reset_mid_creq", 64'(creq.valid), 64'd0);
      else        chk("pre_reset_creq", 64'(creq.valid), 64'd1);
      tick();
    end
    reset = 1'b0;
    cresp = '0;
    #1;
    chk("after_reset_idle_creq", 64'(creq.valid), 64'd0);
    chk("after_reset_line_invalid", 64'(iresp.data_ok), 64'd0);
    tick();
    serve_burst(64'h8000_0080, -1);
    #1;
    chk("restart_data_ok", 64'(iresp.data_ok), 64'd1);
    chk("restart_data", 64'(iresp.data), 64'h8000_0080);
    tick();
    ireq.valid = 1'b0;

`ifdef ICACHE_UNCACHED_EN
    ireq.valid = 1'b1;
    ireq.addr  = 64'h1000_0004;
    #1;
    chk("unc_no_hit", 64'(iresp.data_ok), 64'd0);
    tick();
    chk("unc_creq_valid", 64'(creq.valid), 64'd1);
    chk("unc_creq_size", 64'(creq.size), 64'(MSIZE4));
    chk("unc_creq_len", 64'(creq.len), 64'd0);
    chk("unc_creq_addr", creq.addr, 64'h1000_0004);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    cresp = '0;
    #1;
    chk("unc_data_ok", 64'(iresp.data_ok), 64'd1);
    chk("unc_data", 64'(iresp.data), 64'hAAAA_BBBB);
    chk("unc_creq_dropped", 64'(creq.valid), 64'd0);
    ireq.valid = 1'b0;
    tick();
    chk("unc_one_cycle", 64'(iresp.data_ok), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
